ysyx_25040101_ifu: RTL and testbench
====================================

Name: ysyx_25040101_ifu

Overview:
Multi-cycle instruction fetch unit placed directly upstream of the core datapath; it replaces the combinational pc→rom→inst path.
- Owns the architectural PC.
- Issues one read per instruction to instruction memory over a valid/ready request/response bus.
- Holds the fetched word stable for the datapath until the datapath signals completion and returns the next PC.

Parameters:
RESET_PC, 32'h8000_0000, PC loaded on reset; first fetch address
TIMEOUT_CYCLES, 255, max cycles in WAIT before fetch is declared failed; 0 disables timeout
CNT_W, 8, width of timeout counter; TIMEOUT_CYCLES must fit in CNT_W

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
pc_o  out  32  PC of the instruction currently fetched/held
inst_o  out  32  fetched instruction word, valid when inst_valid_o
inst_valid_o  out  1  inst_o/pc_o hold a valid instruction for the datapath
inst_ready_i  in  1  datapath finished the held instruction this cycle
next_pc_i  in  32  next PC from datapath, sampled when inst_valid_o & inst_ready_i
req_valid_o  out  1  memory read request valid
req_addr_o  out  32  memory read address (word aligned)
req_ready_i  in  1  memory accepts request
resp_valid_i  in  1  memory response valid
resp_data_i  in  32  memory read data
resp_err_i  in  1  memory access error, qualified by resp_valid_i
resp_ready_o  out  1  IFU accepts response
fault_o  out  1  sticky fetch fault, cleared only by rst
fault_pc_o  out  32  PC that caused the fault

Behaviour:
- Reset (rst high at an edge):
  - state=RST, pc=RESET_PC, inst=0, fault_o=0, fault_pc_o=0, timeout counter=0.
  - All valid/ready outputs are 0 while in RST.
  - rst asserted in any state, mid-transaction included, aborts immediately; outstanding responses are dropped because resp_ready_o=0 in RST.
- RST:
  - Next cycle → REQ.
  - If RESET_PC[1:0]≠0 → FAULT instead.
- REQ:
  - req_valid_o=1, req_addr_o=pc; address held stable until handshake.
  - req_valid_o & req_ready_i → WAIT, counter cleared.
  - resp_ready_o=0 in REQ, so a response cannot complete in the same cycle as its request.
- WAIT:
  - resp_ready_o=1; counter increments each cycle.
  - resp_valid_i & !resp_err_i → inst<=resp_data_i, go to HOLD.
  - resp_valid_i & resp_err_i → FAULT, fault_pc_o<=pc.
  - TIMEOUT_CYCLES≠0 and counter==TIMEOUT_CYCLES-1 with no response → FAULT.
  - A response in the same cycle as the timeout wins.
- HOLD:
  - inst_valid_o=1; inst_o and pc_o stable.
  - inst_ready_i=1: pc<=next_pc_i, inst_valid_o drops next cycle.
    - If next_pc_i[1:0]==0 → REQ.
    - Otherwise → FAULT with fault_pc_o<=next_pc_i.
  - inst_ready_i while not in HOLD is ignored.
- FAULT:
  - fault_o=1; req_valid_o=0, resp_ready_o=0, inst_valid_o=0.
  - Absorbing state; exit only via rst.
- Outputs:
  - pc_o=pc in every state; inst_o retains its last captured value outside HOLD.
  - All outputs are registered or decoded from state only; no combinational path from any input to any output.
- Throughput:
  - Zero-wait memory (req_ready_i=1, resp_valid_i the cycle after acceptance) gives request issued in cycle t, response in t+1, inst_valid_o in t+2.
  - Minimum 3 cycles per instruction when the datapath returns inst_ready_i in its first HOLD cycle.

Decomposition:
- Shared package ysyx_25040101_defs holds:
  - state encoding: RST, REQ, WAIT, HOLD, FAULT (3-bit);
  - RESET_PC default;
  - the instruction word width constant.
- No sub-module required.
- The timeout counter stays inline.

Test Plan:
- Reset then zero-wait memory returning 32'h0010_0073 → req_addr_o=32'h8000_0000 in cycle 1; inst_valid_o=1, inst_o=32'h0010_0073 in cycle 3; fault_o=0.
- req_ready_i held low 5 cycles → req_valid_o stays 1 with req_addr_o constant for 5 cycles; handshake on cycle 6; resp_ready_o is never 1 during REQ.
- HOLD with inst_ready_i=1, next_pc_i=32'h8000_0010 → next REQ drives req_addr_o=32'h8000_0010; pc_o updates the cycle after the handshake.
- next_pc_i=32'h8000_0012 accepted → FAULT; fault_o=1, fault_pc_o=32'h8000_0012; no further req_valid_o until rst.
- Response with resp_err_i=1 at pc=32'h8000_0004 → fault_o=1, fault_pc_o=32'h8000_0004. Separately, with TIMEOUT_CYCLES=4 and no response → fault_o=1 exactly 4 cycles after entering WAIT.
- rst pulsed during WAIT, then a stale resp_valid_i arrives → resp_ready_o=0 and the stale response is ignored; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/ysyx_25040101_defs.sv
// Shared definitions for the instruction fetch unit: state encoding, reset PC
// and instruction word width.
package ysyx_25040101_defs;

   localparam int unsigned INST_W       = 32;
   localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;

   typedef enum logic [2:0] {
      ST_RST   = 3'd0,
      ST_REQ   = 3'd1,
      ST_WAIT  = 3'd2,
      ST_HOLD  = 3'd3,
      ST_FAULT = 3'd4
   } ifu_state_e;

endpackage

// File: rtl/ysyx_25040101_ifu.sv
// Multi-cycle instruction fetch unit: owns the PC, fetches one word per
// instruction over a valid/ready bus and holds it until the datapath retires it.
module ysyx_25040101_ifu
   import ysyx_25040101_defs::*;
#(
   parameter logic [31:0] RESET_PC       = RESET_PC_DEF,
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned CNT_W          = 8
) (
   input  logic              clk,
   input  logic              rst,
   output logic [31:0]       pc_o,
   output logic [INST_W-1:0] inst_o,
   output logic              inst_valid_o,
   input  logic              inst_ready_i,
   input  logic [31:0]       next_pc_i,
   output logic              req_valid_o,
   output logic [31:0]       req_addr_o,
   input  logic              req_ready_i,
   input  logic              resp_valid_i,
   input  logic [INST_W-1:0] resp_data_i,
   input  logic              resp_err_i,
   output logic              resp_ready_o,
   output logic              fault_o,
   output logic [31:0]       fault_pc_o
);

   ifu_state_e        state_q;
   logic [31:0]       pc_q;
   logic [INST_W-1:0] inst_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              fault_q;
   logic [31:0]       fault_pc_q;
   logic              req_valid_q;
   logic              resp_ready_q;
   logic              inst_valid_q;

   // Handshake outputs are registered alongside every state transition.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_RST;
         pc_q         <= RESET_PC;
         inst_q       <= '0;
         cnt_q        <= '0;
         fault_q      <= 1'b0;
         fault_pc_q   <= '0;
         req_valid_q  <= 1'b0;
         resp_ready_q <= 1'b0;
         inst_valid_q <= 1'b0;
      end else begin
         case (state_q)
            ST_RST: begin
               if (RESET_PC[1:0] != 2'b00) begin
                  state_q    <= ST_FAULT;
                  fault_q    <= 1'b1;
                  fault_pc_q <= RESET_PC;
               end else begin
                  state_q     <= ST_REQ;
                  req_valid_q <= 1'b1;
               end
            end
            ST_REQ: begin
               if (req_ready_i) begin
                  state_q      <= ST_WAIT;
                  req_valid_q  <= 1'b0;
                  resp_ready_q <= 1'b1;
                  cnt_q        <= '0;
               end
            end
            ST_WAIT: begin
               // A response arriving on the timeout cycle takes priority.
               if (resp_valid_i) begin
                  resp_ready_q <= 1'b0;
                  if (resp_err_i) begin
                     state_q    <= ST_FAULT;
                     fault_q    <= 1'b1;
                     fault_pc_q <= pc_q;
                  end else begin
                     state_q      <= ST_HOLD;
                     inst_q       <= resp_data_i;
                     inst_valid_q <= 1'b1;
                  end
               end else if ((TIMEOUT_CYCLES != 0) &&
                            (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1))) begin
                  state_q      <= ST_FAULT;
                  resp_ready_q <= 1'b0;
                  fault_q      <= 1'b1;
                  fault_pc_q   <= pc_q;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            ST_HOLD: begin
               if (inst_ready_i) begin
                  pc_q         <= next_pc_i;
                  inst_valid_q <= 1'b0;
                  if (next_pc_i[1:0] == 2'b00) begin
                     state_q     <= ST_REQ;
                     req_valid_q <= 1'b1;
                  end else begin
                     state_q    <= ST_FAULT;
                     fault_q    <= 1'b1;
                     fault_pc_q <= next_pc_i;
                  end
               end
            end
            ST_FAULT: begin
               state_q <= ST_FAULT;
            end
            default: begin
               state_q      <= ST_FAULT;
               fault_q      <= 1'b1;
               fault_pc_q   <= pc_q;
               req_valid_q  <= 1'b0;
               resp_ready_q <= 1'b0;
               inst_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign pc_o         = pc_q;
   assign inst_o       = inst_q;
   assign inst_valid_o = inst_valid_q;
   assign req_valid_o  = req_valid_q;
   assign req_addr_o   = pc_q;
   assign resp_ready_o = resp_ready_q;
   assign fault_o      = fault_q;
   assign fault_pc_o   = fault_pc_q;

endmodule

// File: tb/tb_ysyx_25040101_ifu.sv
// Bench for the fetch unit: the bench plays memory and datapath; expected
// fetches go to a queue that a negedge monitor pops when inst_valid_o rises.
module tb_ysyx_25040101_ifu;

   localparam logic [31:0] RST_PC = 32'h8000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc_o, inst_o, req_addr_o, fault_pc_o;
   logic [31:0] next_pc_i, resp_data_i;
   logic        inst_valid_o, inst_ready_i, req_valid_o, req_ready_i;
   logic        resp_valid_i, resp_err_i, resp_ready_o, fault_o;

   ysyx_25040101_ifu #(.RESET_PC(RST_PC), .TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .pc_o(pc_o), .inst_o(inst_o),
      .inst_valid_o(inst_valid_o), .inst_ready_i(inst_ready_i), .next_pc_i(next_pc_i),
      .req_valid_o(req_valid_o), .req_addr_o(req_addr_o), .req_ready_i(req_ready_i),
      .resp_valid_i(resp_valid_i), .resp_data_i(resp_data_i), .resp_err_i(resp_err_i),
      .resp_ready_o(resp_ready_o), .fault_o(fault_o), .fault_pc_o(fault_pc_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] mem [logic [31:0]];
   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] model_pc;
   logic [31:0] acc_addr;
   logic        prev_valid = 1'b0;

   function automatic void chk(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endfunction

   function automatic logic [31:0] get_word(input logic [31:0] addr);
      if (!mem.exists(addr)) mem[addr] = $urandom;
      return mem[addr];
   endfunction

   // Monitor: every newly presented instruction must match the oldest expected fetch.
   always @(negedge clk) begin
      exp_t e;
      if (req_valid_o) chk("resp_ready_during_req", 32'(resp_ready_o), 32'd0);
      if (inst_valid_o && !prev_valid) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_inst: got pc %h inst %h, expected none", pc_o, inst_o);
         end else begin
            e = exp_q.pop_front();
            chk("inst_pc", pc_o, e.pc);
            chk("inst_word", inst_o, e.inst);
         end
      end
      prev_valid <= inst_valid_o;
   end

   task automatic idle_inputs();
      inst_ready_i = 1'b0; next_pc_i = '0; req_ready_i = 1'b0;
      resp_valid_i = 1'b0; resp_data_i = '0; resp_err_i = 1'b0;
   endtask

   task automatic reset_dut();
      rst = 1'b1;
      idle_inputs();
      @(negedge clk);
      @(negedge clk);
      chk("rst_pc", pc_o, RST_PC);
      chk("rst_inst", inst_o, 32'd0);
      chk("rst_inst_valid", 32'(inst_valid_o), 32'd0);
      chk("rst_req_valid", 32'(req_valid_o), 32'd0);
      chk("rst_resp_ready", 32'(resp_ready_o), 32'd0);
      chk("rst_fault", 32'(fault_o), 32'd0);
      chk("rst_fault_pc", fault_pc_o, 32'd0);
      rst = 1'b0;
      model_pc = RST_PC;
      exp_q.delete();
   endtask

   // Drive one request handshake after 'stall' cycles of req_ready_i low.
   task automatic do_req(input int stall);
      int n = 0;
      while (!req_valid_o && n < 8) begin
         @(negedge clk);
         n++;
      end
      chk("req_valid", 32'(req_valid_o), 32'd1);
      chk("req_addr", req_addr_o, model_pc);
      for (int i = 0; i < stall; i++) begin
         inst_ready_i = 1'($urandom_range(0, 1));
         next_pc_i    = $urandom;
         @(negedge clk);
         chk("req_valid_stall", 32'(req_valid_o), 32'd1);
         chk("req_addr_stall", req_addr_o, model_pc);
      end
      inst_ready_i = 1'b0;
      acc_addr     = req_addr_o;
      req_ready_i  = 1'b1;
      @(negedge clk);
      req_ready_i = 1'b0;
      chk("wait_req_valid", 32'(req_valid_o), 32'd0);
      chk("wait_resp_ready", 32'(resp_ready_o), 32'd1);
   endtask

   // Memory response after 'lat' cycles in WAIT, optionally an error.
   task automatic do_resp(input int lat, input logic err);
      exp_t e;
      for (int i = 0; i < lat; i++) begin
         inst_ready_i = 1'($urandom_range(0, 1));
         next_pc_i    = $urandom;
         @(negedge clk);
         chk("wait_no_inst", 32'(inst_valid_o), 32'd0);
         chk("wait_no_fault", 32'(fault_o), 32'd0);
      end
      inst_ready_i = 1'b0;
      resp_valid_i = 1'b1;
      resp_err_i   = err;
      resp_data_i  = get_word(acc_addr);
      if (!err) begin
         e.pc   = model_pc;
         e.inst = get_word(model_pc);
         exp_q.push_back(e);
      end
      @(negedge clk);
      resp_valid_i = 1'b0;
      resp_err_i   = 1'b0;
      if (err) begin
         chk("err_fault", 32'(fault_o), 32'd1);
         chk("err_fault_pc", fault_pc_o, model_pc);
      end else begin
         chk("hold_inst_valid", 32'(inst_valid_o), 32'd1);
         chk("hold_resp_ready", 32'(resp_ready_o), 32'd0);
      end
   endtask

   // Datapath retires the held instruction after 'hold' extra cycles.
   task automatic do_retire(input int hold, input logic [31:0] npc);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk("hold_valid", 32'(inst_valid_o), 32'd1);
         chk("hold_pc", pc_o, model_pc);
      end
      inst_ready_i = 1'b1;
      next_pc_i    = npc;
      @(negedge clk);
      inst_ready_i = 1'b0;
      next_pc_i    = $urandom;
      model_pc     = npc;
      chk("retire_pc", pc_o, npc);
      chk("retire_valid_drop", 32'(inst_valid_o), 32'd0);
      if (npc[1:0] != 2'b00) begin
         chk("misalign_fault", 32'(fault_o), 32'd1);
         chk("misalign_fault_pc", fault_pc_o, npc);
      end else begin
         chk("next_req_valid", 32'(req_valid_o), 32'd1);
      end
   endtask

   task automatic check_absorb();
      for (int i = 0; i < 4; i++) begin
         req_ready_i = 1'b1; resp_valid_i = 1'b1; inst_ready_i = 1'b1; next_pc_i = RST_PC;
         @(negedge clk);
         chk("fault_sticky", 32'(fault_o), 32'd1);
         chk("fault_no_req", 32'(req_valid_o), 32'd0);
         chk("fault_no_resp_ready", 32'(resp_ready_o), 32'd0);
         chk("fault_no_inst", 32'(inst_valid_o), 32'd0);
      end
      idle_inputs();
   endtask

   initial begin
      mem[RST_PC] = 32'h0010_0073;
      reset_dut();

      // Zero-wait fetch, then a 5-cycle request stall and a timeout-edge response.
      do_req(0);
      do_resp(0, 1'b0);
      chk("first_inst", inst_o, 32'h0010_0073);
      chk("first_no_fault", 32'(fault_o), 32'd0);
      do_retire(0, 32'h8000_0010);
      do_req(5);
      do_resp(3, 1'b0);
      do_retire(2, 32'h8000_0004);

      // Error response faults at the requesting PC.
      do_req(0);
      do_resp(1, 1'b1);
      check_absorb();

      // Misaligned next PC faults.
      reset_dut();
      do_req(0);
      do_resp(0, 1'b0);
      do_retire(1, 32'h8000_0012);
      check_absorb();

      // No response: fault exactly four cycles after entering WAIT.
      reset_dut();
      do_req(1);
      chk("to_cycle0", 32'(fault_o), 32'd0);
      for (int i = 1; i < 4; i++) begin
         @(negedge clk);
         chk("to_before", 32'(fault_o), 32'd0);
      end
      @(negedge clk);
      chk("to_fault", 32'(fault_o), 32'd1);
      chk("to_fault_pc", fault_pc_o, RST_PC);
      chk("to_resp_ready", 32'(resp_ready_o), 32'd0);
      check_absorb();

      // Reset mid-WAIT, then a stale response must be ignored.
      reset_dut();
      do_req(0);
      rst = 1'b1;
      @(negedge clk);
      chk("stale_rst_resp_ready", 32'(resp_ready_o), 32'd0);
      chk("stale_rst_pc", pc_o, RST_PC);
      rst = 1'b0;
      resp_valid_i = 1'b1;
      resp_data_i  = 32'hDEAD_BEEF;
      @(negedge clk);
      chk("stale_req_valid", 32'(req_valid_o), 32'd1);
      chk("stale_resp_ready", 32'(resp_ready_o), 32'd0);
      chk("stale_addr", req_addr_o, RST_PC);
      chk("stale_no_inst", 32'(inst_valid_o), 32'd0);
      resp_valid_i = 1'b0;
      model_pc = RST_PC;
      exp_q.delete();
      do_req(0);
      do_resp(0, 1'b0);
      do_retire(0, RST_PC + 32'h4);

      // Random traffic with varying stall, latency and hold times.
      for (int k = 0; k < 40; k++) begin
         do_req($urandom_range(0, 3));
         do_resp($urandom_range(0, 3), 1'b0);
         do_retire($urandom_range(0, 3), RST_PC + (32'($urandom_range(0, 1023)) << 2));
      end

      repeat (3) @(negedge clk);
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      chk("final_no_fault", 32'(fault_o), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
